// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
// - State encoding for the divider FSM (2 bits: IDLE / CALC / DONE).
// - Operation encoding used by the EXE stage to select quotient or remainder.
// - Helper for the derived iteration counter width.
package div_pkg;

    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_IDLE = 2'd0;
    localparam div_state_t DIV_CALC = 2'd1;
    localparam div_state_t DIV_DONE = 2'd2;

    // EXE-side operation select: signedness and which result is written back.
    typedef enum logic [1:0] {
        DIV_OP_DIV_W  = 2'd0,
        DIV_OP_MOD_W  = 2'd1,
        DIV_OP_DIV_WU = 2'd2,
        DIV_OP_MOD_WU = 2'd3
    } div_op_e;

    function automatic logic div_op_is_signed(input div_op_e op);
        return (op == DIV_OP_DIV_W) || (op == DIV_OP_MOD_W);
    endfunction

    function automatic logic div_op_wants_rem(input div_op_e op);
        return (op == DIV_OP_MOD_W) || (op == DIV_OP_MOD_WU);
    endfunction

    // Counter must hold the value WIDTH itself.
    function automatic int div_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, purely combinational.
// Used both to take operand magnitudes and to apply the result signs.
// Ports:
//   value  - input value (magnitude or raw operand)
//   negate - 1 = return -value
//   hold   - 1 = suppress the negate (e.g. quotient of a divide by zero)
//   result - corrected value
module div_sign_fix
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    input  logic             hold,
    output logic [WIDTH-1:0] result
);

    // Negating 2^(WIDTH-1) wraps back onto itself, which is exactly what the
    // unsigned magnitude of the most negative operand needs.
    assign result = (negate && !hold) ? ((~value) + WIDTH'(1)) : value;

endmodule

// File: rtl/iter_div_unit.sv
// Radix-2 restoring integer divider, signed and unsigned, one quotient bit
// per cycle. Quotient and remainder are delivered together through a
// valid/ready handshake; flush cancels any operation in flight.
// Optional build macro: ITER_DIV_EARLY_OUT_EN - when defined, a divide by
// zero or |dividend| < |divisor| bypasses the iteration and completes in one
// cycle.
// Ports:
//   clk, resetn         - clock, synchronous active-low reset
//   in_valid/in_ready   - request handshake (ready only while idle)
//   in_signed           - operands are two's complement
//   in_dividend/divisor - operands
//   flush               - cancel, return to idle, no result
//   out_valid/out_ready - result handshake
//   out_quotient/remainder - registered results, stable while out_valid
//   busy                - unit is not idle
module iter_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = div_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             busy
);

    div_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] dvd_reg;    // dividend bits, quotient bits shift in at the LSB
    logic [WIDTH-1:0] dsr_reg;    // divisor magnitude
    logic [WIDTH-1:0] prem_reg;   // partial remainder
    logic             qneg_reg;
    logic             rneg_reg;
    logic             dzero_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;

    // Operand magnitudes: index 0 = dividend, 1 = divisor.
    logic [WIDTH-1:0] op_raw [2];
    logic [WIDTH-1:0] op_mag [2];

    assign op_raw[0] = in_dividend;
    assign op_raw[1] = in_divisor;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_abs
            div_sign_fix #(.WIDTH(WIDTH)) u_abs (
                .value  (op_raw[gi]),
                .negate (in_signed & op_raw[gi][WIDTH-1]),
                .hold   (1'b0),
                .result (op_mag[gi])
            );
        end
    endgenerate

    logic in_divisor_zero;
    assign in_divisor_zero = (in_divisor == '0);

`ifdef ITER_DIV_EARLY_OUT_EN
    logic early_hit;
    assign early_hit = in_divisor_zero || (op_mag[0] < op_mag[1]);
`endif

    // One restoring step. Since prem < divisor, the trial fits WIDTH+1 bits
    // and its MSB is a reliable borrow flag.
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] prem_next;
    logic [WIDTH-1:0] dvd_next;

    assign trial     = {prem_reg, dvd_reg[WIDTH-1]} - {1'b0, dsr_reg};
    assign q_bit     = ~trial[WIDTH];
    assign prem_next = q_bit ? trial[WIDTH-1:0] : {prem_reg[WIDTH-2:0], dvd_reg[WIDTH-1]};
    assign dvd_next  = {dvd_reg[WIDTH-2:0], q_bit};

    // Final sign correction, applied on the last iteration so the outputs are
    // plain registers. A zero divisor keeps the all-ones quotient; the
    // remainder still negates, which restores the original dividend.
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .value  (dvd_next),
        .negate (qneg_reg),
        .hold   (dzero_reg),
        .result (quo_fixed)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (prem_next),
        .negate (rneg_reg),
        .hold   (1'b0),
        .result (rem_fixed)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= DIV_IDLE;
            cnt_reg   <= '0;
            dvd_reg   <= '0;
            dsr_reg   <= '0;
            prem_reg  <= '0;
            qneg_reg  <= 1'b0;
            rneg_reg  <= 1'b0;
            dzero_reg <= 1'b0;
            quo_reg   <= '0;
            rem_reg   <= '0;
        end else if (flush) begin
            state_reg <= DIV_IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                DIV_IDLE: begin
                    if (in_valid) begin
                        dvd_reg   <= op_mag[0];
                        dsr_reg   <= op_mag[1];
                        prem_reg  <= '0;
                        qneg_reg  <= (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]) & in_signed;
                        rneg_reg  <= in_dividend[WIDTH-1] & in_signed;
                        dzero_reg <= in_divisor_zero;
                        cnt_reg   <= CNT_W'(WIDTH);
`ifdef ITER_DIV_EARLY_OUT_EN
                        if (early_hit) begin
                            state_reg <= DIV_DONE;
                            quo_reg   <= in_divisor_zero ? '1 : '0;
                            rem_reg   <= in_dividend;
                        end else begin
                            state_reg <= DIV_CALC;
                        end
`else
                        state_reg <= DIV_CALC;
`endif
                    end
                end
                DIV_CALC: begin
                    prem_reg <= prem_next;
                    dvd_reg  <= dvd_next;
                    cnt_reg  <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= DIV_DONE;
                        quo_reg   <= quo_fixed;
                        rem_reg   <= rem_fixed;
                    end
                end
                DIV_DONE: begin
                    if (out_ready) begin
                        state_reg <= DIV_IDLE;
                    end
                end
                default: state_reg <= DIV_IDLE;
            endcase
        end
    end

    assign in_ready      = (state_reg == DIV_IDLE);
    assign out_valid     = (state_reg == DIV_DONE);
    assign busy          = (state_reg != DIV_IDLE);
    assign out_quotient  = quo_reg;
    assign out_remainder = rem_reg;

endmodule

// File: tb/tb_iter_div_unit.sv
module tb_iter_div_unit;

`ifdef ITER_DIV_EARLY_OUT_EN
    localparam int LAT_EARLY = 1;
`else
    localparam int LAT_EARLY = 33;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        resetn, in_valid, in_ready, in_signed, flush;
    logic        out_valid, out_ready, busy;
    logic [31:0] in_dividend, in_divisor, out_quotient, out_remainder;

    // 8-bit instance for random checks against the reference model
    logic        b_in_valid, b_in_ready, b_in_signed, b_flush;
    logic        b_out_valid, b_out_ready, b_busy;
    logic [7:0]  b_in_dividend, b_in_divisor, b_out_quotient, b_out_remainder;

    iter_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .in_dividend(in_dividend), .in_divisor(in_divisor),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder), .busy(busy)
    );

    iter_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_signed(b_in_signed), .in_dividend(b_in_dividend), .in_divisor(b_in_divisor),
        .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_quotient(b_out_quotient), .out_remainder(b_out_remainder), .busy(b_busy)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    typedef struct packed {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic [7:0]  lat;
    } vec_t;

    exp_t sb[$];
    exp_t sb8[$];
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: signed division truncates toward zero, remainder follows
    // the dividend; a zero divisor gives all ones / dividend.
    function automatic void model(input int w, input bit sgn,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned q, output longint unsigned r);
        longint unsigned mask;
        longint sa, sd;
        mask = (64'd1 << w) - 64'd1;
        if (b == 0) begin
            q = mask;
            r = a;
        end else if (sgn) begin
            sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
            sd = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
            q = 64'(sa / sd) & mask;
            r = 64'(sa % sd) & mask;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Present a request at the falling edge and hold it until accepted.
    // Returns at the falling edge right after the accepting rising edge.
    task automatic start(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input string name);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_signed = sgn; in_dividend = a; in_divisor = b;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({name, " accept timeout"}, 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back('{q: eq, r: er});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for the result, compare it with the scoreboard, optionally hold
    // out_ready low for 'hold' cycles while a new request is offered.
    task automatic wait_result(input string name, input int exp_lat, input int hold);
        int   n;
        bit   saw_ready;
        exp_t e;
        n = 0;
        saw_ready = 1'b0;
        while (!out_valid && n < 100) begin
            saw_ready |= in_ready;
            @(negedge clk);
            n++;
        end
        check({name, " out_valid"}, 64'(out_valid), 64'd1);
        if (!out_valid) return;
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        check({name, " quotient"}, 64'(out_quotient), 64'(e.q));
        check({name, " remainder"}, 64'(out_remainder), 64'(e.r));
        check({name, " in_ready low while busy"}, 64'(saw_ready), 64'd0);
        if (exp_lat > 0) check({name, " latency"}, 64'(n + 1), 64'(exp_lat));
        $display("[TB] %s: q=0x%08h r=0x%08h latency=%0d", name, out_quotient, out_remainder, n + 1);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; in_signed = 1'b0; in_dividend = 32'd77; in_divisor = 32'd5;
            @(negedge clk);
            check({name, " hold quotient stable"}, 64'(out_quotient), 64'(e.q));
            check({name, " hold remainder stable"}, 64'(out_remainder), 64'(e.r));
            check({name, " hold no accept"}, 64'({out_valid, in_ready}), 64'b10);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " idle after handshake"}, 64'({out_valid, in_ready, busy}), 64'b010);
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        longint unsigned mq, mr;
        int n;
        bit seen;
        logic [7:0] ra, rb;
        bit rs;

        resetn = 1'b0; in_valid = 1'b0; in_signed = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_dividend = '0; in_divisor = '0;
        b_in_valid = 1'b0; b_in_signed = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        b_in_dividend = '0; b_in_divisor = '0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        8'd33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF, 8'd33};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,        8'd33};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,        8'd33};
        vecs[4]  = '{1'b1, 32'h12345678,   32'd0,        32'hFFFFFFFF,  32'h12345678, 8'(LAT_EARLY)};
        vecs[5]  = '{1'b0, 32'h12345678,   32'd0,        32'hFFFFFFFF,  32'h12345678, 8'(LAT_EARLY)};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0,        8'd33};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE, 8'd33};
        vecs[8]  = '{1'b0, 32'hFFFFFF9C,   32'd7,        32'h24924916,  32'd2,        8'd33};
        vecs[9]  = '{1'b1, 32'h80000000,   32'd0,        32'hFFFFFFFF,  32'h80000000, 8'(LAT_EARLY)};
        vecs[10] = '{1'b1, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF,  32'hFFFFFFF9, 8'(LAT_EARLY)};
        vecs[11] = '{1'b0, 32'd5,          32'd10,       32'd0,         32'd5,        8'(LAT_EARLY)};

        repeat (3) @(negedge clk);
        check("reset state", 64'({in_ready, out_valid, busy}), 64'b100);
        check("reset quotient", 64'(out_quotient), 64'd0);
        check("reset remainder", 64'(out_remainder), 64'd0);
        check("reset w8 state", 64'({b_in_ready, b_out_valid, b_busy}), 64'b100);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));
            wait_result($sformatf("vec%0d", i), int'(vecs[i].lat), 0);
        end

        // Back-pressure: result held for 5 cycles, no reissue on the handshake edge.
        start(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, "backpressure");
        wait_result("backpressure", 33, 5);

        // Flush at CALC cycle 10 with a new request held on in_valid.
        start(1'b0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32'd0, "flush victim");
        repeat (9) @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1; in_signed = 1'b0; in_dividend = 32'd1000; in_divisor = 32'd3;
        @(negedge clk);
        flush = 1'b0;
        sb.delete();
        check("flush -> idle", 64'({out_valid, in_ready, busy}), 64'b010);
        @(posedge clk);
        sb.push_back('{q: 32'd333, r: 32'd1});
        @(negedge clk);
        in_valid = 1'b0;
        check("post-flush accept", 64'(busy), 64'd1);
        wait_result("post-flush", 33, 0);

        // Reset in the middle of an operation.
        start(1'b0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32'd0, "reset victim");
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("mid reset state", 64'({in_ready, out_valid, busy}), 64'b100);
        check("mid reset quotient", 64'(out_quotient), 64'd0);
        check("mid reset remainder", 64'(out_remainder), 64'd0);
        resetn = 1'b1;
        sb.delete();
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("no result after reset", 64'(seen), 64'd0);

`ifdef ITER_DIV_EARLY_OUT_EN
        start(1'b0, 32'd3, 32'd200, 32'd0, 32'd3, "early 3/200");
        wait_result("early 3/200", 1, 0);
`endif

        // WIDTH=8 random signed/unsigned against the reference model.
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            case (i % 8)
                0: rb = 8'h00;
                1: begin ra = 8'h80; rb = 8'hFF; end
                2: rb = 8'h80;
                default: rb = 8'($urandom);
            endcase
            model(8, rs, 64'(ra), 64'(rb), mq, mr);
            @(negedge clk);
            b_in_valid = 1'b1; b_in_signed = rs; b_in_dividend = ra; b_in_divisor = rb;
            @(posedge clk);
            sb8.push_back('{q: 32'(mq), r: 32'(mr)});
            @(negedge clk);
            b_in_valid = 1'b0;
            n = 0;
            while (!b_out_valid && n < 30) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("w8 #%0d out_valid", i), 64'(b_out_valid), 64'd1);
            if (b_out_valid && sb8.size() > 0) begin
                exp_t e;
                e = sb8.pop_front();
                check($sformatf("w8 #%0d quotient", i), 64'(b_out_quotient), 64'(e.q[7:0]));
                check($sformatf("w8 #%0d remainder", i), 64'(b_out_remainder), 64'(e.r[7:0]));
                $display("[TB] w8 #%0d %s 0x%02h/0x%02h: q=0x%02h r=0x%02h", i, rs ? "s" : "u",
                         ra, rb, b_out_quotient, b_out_remainder);
            end
            b_out_ready = 1'b1;
            @(negedge clk);
            b_out_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
